// File: rtl/e203_exu_longp_wbck_q_pkg.sv
// Purpose : shared widths for the long-pipe write-back queue (thread, data, rd index).
// Latency : n/a (constants and a width helper only).
// Backpressure: n/a.
package e203_exu_longp_wbck_q_pkg;

   localparam int E203_THREADS_NUM  = 2;
   localparam int E203_XLEN         = 32;
   localparam int E203_FLEN         = 32;
   localparam int E203_RFIDX_WIDTH  = 5;

   // Queue entry = thread_sel + wdat + rdidx + rdfpu + err
   function automatic int wbck_q_ent_w(input int threads, input int flen, input int rfidx_w);
      return threads + flen + rfidx_w + 2;
   endfunction

   localparam int WBCK_Q_ENT_W = wbck_q_ent_w(E203_THREADS_NUM, E203_FLEN, E203_RFIDX_WIDTH);

endpackage

// File: rtl/e203_exu_wbck_fifo.sv
// Purpose : generic DEPTH x W synchronous in-order FIFO (push/pop, full/empty, head data).
// Latency : a pushed entry is visible at head_o on the following cycle; no bypass.
// Backpressure: full_o is the producer's stall; push while full and pop while empty are ignored.
// Ports   : clk/rst (sync, active-high), push_i/dat_i write side, pop_i/head_o read side,
//           full_o/empty_o status.
module e203_exu_wbck_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] dat_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload storage is deliberately not reset; occupancy is tracked by cnt_q.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= dat_i;
   end

endmodule

// File: rtl/e203_exu_longp_wbck_q.sv
// Purpose : round-robin merge of LSU/MULDIV completions into an in-order queue; head goes to
//           write-back (err=0) or exception report (err=1), each pop pulses OITF retire.
// Latency : one cycle from accepted input to queue head; no bypass.
// Backpressure: input readys drop only when the queue is full; they never look at output readys.
// Ports   : lsu_i_* / mdv_i_* completion inputs, longp_wbck_o_* write-back port,
//           longp_excp_o_* error port, oitf_ret_* retire strobe, clk/rst (sync, active-high).
module e203_exu_longp_wbck_q
   import e203_exu_longp_wbck_q_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int THREADS = E203_THREADS_NUM,
   parameter int XLEN    = E203_XLEN,
   parameter int FLEN    = E203_FLEN,
   parameter int RFIDX_W = E203_RFIDX_WIDTH
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               lsu_i_valid,
   output logic               lsu_i_ready,
   input  logic [THREADS-1:0] lsu_i_thread_sel,
   input  logic [FLEN-1:0]    lsu_i_wdat,
   input  logic [RFIDX_W-1:0] lsu_i_rdidx,
   input  logic               lsu_i_rdfpu,
   input  logic               lsu_i_err,

   input  logic               mdv_i_valid,
   output logic               mdv_i_ready,
   input  logic [THREADS-1:0] mdv_i_thread_sel,
   input  logic [FLEN-1:0]    mdv_i_wdat,
   input  logic [RFIDX_W-1:0] mdv_i_rdidx,
   input  logic               mdv_i_rdfpu,
   input  logic               mdv_i_err,

   output logic               longp_wbck_o_valid,
   input  logic               longp_wbck_o_ready,
   output logic [THREADS-1:0] longp_wbck_o_thread_sel,
   output logic [FLEN-1:0]    longp_wbck_o_wdat,
   output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
   output logic               longp_wbck_o_rdfpu,
   output logic [4:0]         longp_wbck_o_flags,

   output logic               longp_excp_o_valid,
   input  logic               longp_excp_o_ready,
   output logic [THREADS-1:0] longp_excp_o_thread_sel,

   output logic               oitf_ret_ena,
   output logic [THREADS-1:0] oitf_ret_thread_sel
);

   if (FLEN < XLEN) begin : g_bad_flen
      $error("e203_exu_longp_wbck_q: FLEN must be >= XLEN");
   end

   typedef struct packed {
      logic [THREADS-1:0] thread_sel;
      logic [FLEN-1:0]    wdat;
      logic [RFIDX_W-1:0] rdidx;
      logic               rdfpu;
      logic               err;
   } wbck_ent_t;

   localparam int ENT_W = wbck_q_ent_w(THREADS, FLEN, RFIDX_W);

   wbck_ent_t  push_ent, head_ent;
   logic [ENT_W-1:0] head_raw;
   logic       fifo_full, fifo_empty;
   logic       grant_lsu, grant_mdv;
   logic       push, pop;
   logic       last_mdv_q, last_mdv_d;

   // Round-robin: on a tie, the source not granted last wins. Reset favours LSU first.
   assign grant_lsu = lsu_i_valid & (~mdv_i_valid | last_mdv_q);
   assign grant_mdv = mdv_i_valid & ~grant_lsu;

   assign lsu_i_ready = ~fifo_full & grant_lsu;
   assign mdv_i_ready = ~fifo_full & grant_mdv;
   assign push        = (lsu_i_valid & lsu_i_ready) | (mdv_i_valid & mdv_i_ready);

   always_comb begin
      if (grant_mdv) begin
         push_ent = '{thread_sel: mdv_i_thread_sel, wdat: mdv_i_wdat, rdidx: mdv_i_rdidx,
                      rdfpu: mdv_i_rdfpu, err: mdv_i_err};
      end else begin
         push_ent = '{thread_sel: lsu_i_thread_sel, wdat: lsu_i_wdat, rdidx: lsu_i_rdidx,
                      rdfpu: lsu_i_rdfpu, err: lsu_i_err};
      end
   end

   always_comb begin
      last_mdv_d = last_mdv_q;
      if (push) last_mdv_d = grant_mdv;
   end

   always_ff @(posedge clk) begin
      if (rst) last_mdv_q <= 1'b1;
      else     last_mdv_q <= last_mdv_d;
   end

   e203_exu_wbck_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .dat_i   (push_ent),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_raw)
   );

   assign head_ent = head_raw;

   // Head dispatch: the err bit steers the entry to exactly one of the two ports.
   assign longp_wbck_o_valid      = ~fifo_empty & ~head_ent.err;
   assign longp_excp_o_valid      = ~fifo_empty &  head_ent.err;
   assign longp_wbck_o_thread_sel = head_ent.thread_sel;
   assign longp_wbck_o_wdat       = head_ent.wdat;
   assign longp_wbck_o_rdidx      = head_ent.rdidx;
   assign longp_wbck_o_rdfpu      = head_ent.rdfpu;
   assign longp_wbck_o_flags      = 5'd0;
   assign longp_excp_o_thread_sel = head_ent.thread_sel;

   assign pop = (longp_wbck_o_valid & longp_wbck_o_ready) |
                (longp_excp_o_valid & longp_excp_o_ready);

   assign oitf_ret_ena        = pop;
   assign oitf_ret_thread_sel = head_ent.thread_sel;

endmodule

// File: tb/tb_e203_exu_longp_wbck_q.sv
// Purpose : directed self-checking bench for the long-pipe write-back queue.
// Latency : n/a.
// Backpressure: exercised through longp_wbck_o_ready / longp_excp_o_ready.
module tb_e203_exu_longp_wbck_q;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_i_valid, lsu_i_ready, lsu_i_rdfpu, lsu_i_err;
   logic [1:0]  lsu_i_thread_sel;
   logic [31:0] lsu_i_wdat;
   logic [4:0]  lsu_i_rdidx;
   logic        mdv_i_valid, mdv_i_ready, mdv_i_rdfpu, mdv_i_err;
   logic [1:0]  mdv_i_thread_sel;
   logic [31:0] mdv_i_wdat;
   logic [4:0]  mdv_i_rdidx;
   logic        wbck_valid, wbck_ready, wbck_rdfpu;
   logic [1:0]  wbck_thread;
   logic [31:0] wbck_wdat;
   logic [4:0]  wbck_rdidx;
   logic [4:0]  wbck_flags;
   logic        excp_valid, excp_ready;
   logic [1:0]  excp_thread;
   logic        oitf_ena;
   logic [1:0]  oitf_thread;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   e203_exu_longp_wbck_q #(
      .DEPTH(2), .THREADS(2), .XLEN(32), .FLEN(32), .RFIDX_W(5)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .lsu_i_valid             (lsu_i_valid),
      .lsu_i_ready             (lsu_i_ready),
      .lsu_i_thread_sel        (lsu_i_thread_sel),
      .lsu_i_wdat              (lsu_i_wdat),
      .lsu_i_rdidx             (lsu_i_rdidx),
      .lsu_i_rdfpu             (lsu_i_rdfpu),
      .lsu_i_err               (lsu_i_err),
      .mdv_i_valid             (mdv_i_valid),
      .mdv_i_ready             (mdv_i_ready),
      .mdv_i_thread_sel        (mdv_i_thread_sel),
      .mdv_i_wdat              (mdv_i_wdat),
      .mdv_i_rdidx             (mdv_i_rdidx),
      .mdv_i_rdfpu             (mdv_i_rdfpu),
      .mdv_i_err               (mdv_i_err),
      .longp_wbck_o_valid      (wbck_valid),
      .longp_wbck_o_ready      (wbck_ready),
      .longp_wbck_o_thread_sel (wbck_thread),
      .longp_wbck_o_wdat       (wbck_wdat),
      .longp_wbck_o_rdidx      (wbck_rdidx),
      .longp_wbck_o_rdfpu      (wbck_rdfpu),
      .longp_wbck_o_flags      (wbck_flags),
      .longp_excp_o_valid      (excp_valid),
      .longp_excp_o_ready      (excp_ready),
      .longp_excp_o_thread_sel (excp_thread),
      .oitf_ret_ena            (oitf_ena),
      .oitf_ret_thread_sel     (oitf_thread)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      rst = 1'b1;
      lsu_i_valid = 0; lsu_i_thread_sel = 2'b01; lsu_i_wdat = '0; lsu_i_rdidx = '0;
      lsu_i_rdfpu = 0; lsu_i_err = 0;
      mdv_i_valid = 0; mdv_i_thread_sel = 2'b10; mdv_i_wdat = '0; mdv_i_rdidx = '0;
      mdv_i_rdfpu = 0; mdv_i_err = 0;
      wbck_ready = 0; excp_ready = 0;

      // ---- reset state
      repeat (2) tick();
      settle();
      chk("rst_wbck_vld", wbck_valid, 0);
      chk("rst_excp_vld", excp_valid, 0);
      chk("rst_oitf_ena", oitf_ena, 0);
      chk("rst_flags", wbck_flags, 0);
      lsu_i_valid = 1;
      settle();
      chk("rst_lsu_rdy", lsu_i_ready, 1);
      tick();
      rst = 0;
      lsu_i_valid = 0;

      // ---- both sources valid every cycle: grants alternate, LSU first
      wbck_ready = 1;
      for (int i = 0; i < 4; i++) begin
         lsu_i_valid = 1; mdv_i_valid = 1;
         lsu_i_wdat = 32'hA0 + i; mdv_i_wdat = 32'hB0 + i;
         settle();
         chk("rr_lsu_rdy", lsu_i_ready, (i % 2 == 0));
         chk("rr_mdv_rdy", mdv_i_ready, (i % 2 == 1));
         if (i > 0)
            chk("rr_head", wbck_wdat, ((i - 1) % 2 == 0) ? 32'hA0 + i - 1 : 32'hB0 + i - 1);
         tick();
      end
      lsu_i_valid = 0; mdv_i_valid = 0;
      settle();
      chk("rr_last_vld", wbck_valid, 1);
      chk("rr_last_head", wbck_wdat, 32'hB3);
      chk("rr_last_thr", wbck_thread, 2'b10);
      tick();
      settle();
      chk("rr_drained", wbck_valid, 0);

      // ---- single LSU completion
      lsu_i_valid = 1; lsu_i_thread_sel = 2'b01; lsu_i_wdat = 32'h1234; lsu_i_rdidx = 5;
      settle();
      chk("s_lsu_rdy", lsu_i_ready, 1);
      chk("s_no_bypass", wbck_valid, 0);
      tick();
      lsu_i_valid = 0;
      settle();
      chk("s_vld", wbck_valid, 1);
      chk("s_excp", excp_valid, 0);
      chk("s_thr", wbck_thread, 2'b01);
      chk("s_wdat", wbck_wdat, 32'h1234);
      chk("s_rdidx", wbck_rdidx, 5);
      chk("s_rdfpu", wbck_rdfpu, 0);
      chk("s_flags", wbck_flags, 0);
      chk("s_ret", oitf_ena, 1);
      chk("s_ret_thr", oitf_thread, 2'b01);
      tick();
      settle();
      chk("s_ret_once", oitf_ena, 0);
      chk("s_empty", wbck_valid, 0);

      // ---- fill to full with output stalled, then drain
      wbck_ready = 0;
      lsu_i_valid = 1; lsu_i_wdat = 32'hC0;
      settle();
      chk("f_rdy0", lsu_i_ready, 1);
      tick();
      lsu_i_wdat = 32'hC1;
      settle();
      chk("f_rdy1", lsu_i_ready, 1);
      tick();
      lsu_i_wdat = 32'hC2;
      settle();
      chk("f_full_rdy", lsu_i_ready, 0);
      chk("f_head0", wbck_wdat, 32'hC0);
      chk("f_no_ret", oitf_ena, 0);
      tick();
      wbck_ready = 1;
      settle();
      chk("f_pop_full_rdy", lsu_i_ready, 0);
      chk("f_pop_ret", oitf_ena, 1);
      chk("f_pop_head0", wbck_wdat, 32'hC0);
      tick();
      settle();
      chk("f_reopen_rdy", lsu_i_ready, 1);
      chk("f_head1", wbck_wdat, 32'hC1);
      tick();
      lsu_i_valid = 0;
      settle();
      chk("f_head2", wbck_wdat, 32'hC2);
      chk("f_head2_vld", wbck_valid, 1);
      tick();
      settle();
      chk("f_drained", wbck_valid, 0);

      // ---- error entry at head, then normal entry
      wbck_ready = 1; excp_ready = 0;
      mdv_i_valid = 1; mdv_i_thread_sel = 2'b10; mdv_i_err = 1; mdv_i_wdat = 32'hEE;
      mdv_i_rdidx = 7;
      tick();
      mdv_i_valid = 0; mdv_i_err = 0;
      lsu_i_valid = 1; lsu_i_thread_sel = 2'b01; lsu_i_err = 0; lsu_i_wdat = 32'hD0;
      settle();
      chk("e_excp_vld", excp_valid, 1);
      chk("e_wbck_vld", wbck_valid, 0);
      chk("e_excp_thr", excp_thread, 2'b10);
      chk("e_no_ret", oitf_ena, 0);
      tick();
      lsu_i_valid = 0;
      settle();
      chk("e_excp_hold", excp_valid, 1);
      chk("e_wbck_hold", wbck_valid, 0);
      excp_ready = 1;
      settle();
      chk("e_ret", oitf_ena, 1);
      chk("e_ret_thr", oitf_thread, 2'b10);
      tick();
      excp_ready = 0;
      settle();
      chk("e2_wbck_vld", wbck_valid, 1);
      chk("e2_excp_vld", excp_valid, 0);
      chk("e2_wdat", wbck_wdat, 32'hD0);
      chk("e2_ret", oitf_ena, 1);
      chk("e2_ret_thr", oitf_thread, 2'b01);
      tick();
      settle();
      chk("e_drained_w", wbck_valid, 0);
      chk("e_drained_e", excp_valid, 0);

      // ---- reset while two entries are held (last grant = LSU before reset)
      wbck_ready = 0;
      mdv_i_valid = 1; mdv_i_wdat = 32'hF0;
      tick();
      mdv_i_valid = 0;
      lsu_i_valid = 1; lsu_i_wdat = 32'hF1;
      tick();
      lsu_i_valid = 0;
      settle();
      chk("r_held", wbck_valid, 1);
      rst = 1;
      tick();
      rst = 0;
      settle();
      chk("r_wbck_vld", wbck_valid, 0);
      chk("r_excp_vld", excp_valid, 0);
      chk("r_ret", oitf_ena, 0);
      lsu_i_valid = 1; mdv_i_valid = 1; lsu_i_wdat = 32'hF2; mdv_i_wdat = 32'hF3;
      settle();
      chk("r_tie_lsu", lsu_i_ready, 1);
      chk("r_tie_mdv", mdv_i_ready, 0);
      tick();
      lsu_i_valid = 0; mdv_i_valid = 0;
      settle();
      chk("r_head", wbck_wdat, 32'hF2);
      wbck_ready = 1;
      settle();
      chk("r_ret_one", oitf_ena, 1);
      tick();
      settle();
      chk("r_cnt0", wbck_valid, 0);

      // ---- full-rate streaming across pointer wrap
      wbck_ready = 1;
      for (int i = 0; i < 8; i++) begin
         lsu_i_valid = 1; lsu_i_wdat = 32'h100 + i;
         settle();
         chk("w_rdy", lsu_i_ready, 1);
         if (i > 0) chk("w_head", wbck_wdat, 32'h100 + i - 1);
         tick();
      end
      lsu_i_valid = 0;
      settle();
      chk("w_last", wbck_wdat, 32'h107);
      tick();
      settle();
      chk("w_drained", wbck_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/e203_exu_longp_wbck_q.md
# e203_exu_longp_wbck_q

Long-pipeline write-back source queue. It collects completions from the LSU and MULDIV long-pipe units, arbitrates between them round-robin, and buffers them in a small in-order FIFO. At the FIFO head, each entry goes one of two ways: non-error entries go to the long-pipe write-back port of the write-back arbiter; error entries go to the commit/exception port. Every head pop pulses an OITF-retire strobe tagged with the entry's thread.

## Interface
Parameters
- DEPTH, 2: FIFO entries. Power of two, ≥2.
- THREADS, `E203_THREADS_NUM: thread one-hot width.
- XLEN, `E203_XLEN: integer data width.
- FLEN, `E203_FLEN: write data width, ≥XLEN.
- RFIDX_W, `E203_RFIDX_WIDTH: register index width.

Ports
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- lsu_i_valid / lsu_i_ready  in/out  1  LSU completion handshake.
- lsu_i_thread_sel  in  THREADS  one-hot thread of the LSU completion.
- lsu_i_wdat  in  FLEN  LSU result.
- lsu_i_rdidx  in  RFIDX_W  destination register.
- lsu_i_rdfpu  in  1  destination is the FP register file.
- lsu_i_err  in  1  completion faulted.
- mdv_i_*  same set of signals as lsu_i_*  MULDIV completion; mdv_i_rdfpu is tied low by the integrator.
- longp_wbck_o_valid / longp_wbck_o_ready  out/in  1  write-back handshake.
- longp_wbck_o_thread_sel  out  THREADS  thread of the write-back entry.
- longp_wbck_o_wdat  out  FLEN  write-back data.
- longp_wbck_o_rdidx  out  RFIDX_W  destination register.
- longp_wbck_o_rdfpu  out  1  FP destination.
- longp_wbck_o_flags  out  5  FP exception flags; always 0 from this block.
- longp_excp_o_valid / longp_excp_o_ready  out/in  1  error-report handshake.
- longp_excp_o_thread_sel  out  THREADS  thread of the faulting entry.
- oitf_ret_ena  out  1  one-cycle pulse on each head pop.
- oitf_ret_thread_sel  out  THREADS  thread of the popped entry.

## Operation
- Arbitration
  - One grant per cycle, and only when the FIFO is not full.
  - Both sources valid: the grant goes to the source not granted last.
  - One source valid: that source wins.
  - A last-grant flag updates on every accepted push. Its reset value is "MULDIV", so LSU wins the first tie.
- Ready rules
  - lsu_i_ready = ~full & (granted to LSU).
  - mdv_i_ready = ~full & (granted to MULDIV).
  - Ready does not depend on either output ready. A push while full is impossible.
- Entry contents: thread_sel, wdat, rdidx, rdfpu, err.
- Head dispatch
  - Head with err=0: drives longp_wbck_o_valid=1 and longp_excp_o_valid=0.
  - Head with err=1: drives longp_excp_o_valid=1 and longp_wbck_o_valid=0.
  - Both valids are 0 when the FIFO is empty.
- Pop happens on the active port's valid&ready.
  - oitf_ret_ena = pop, combinational.
  - oitf_ret_thread_sel = head thread_sel.
- Data outputs show the head entry whenever not empty. Their value when empty is don't-care; RTL drives the head slot contents.

## Timing
- Latency: an accepted input appears at the output head on the next cycle at the earliest. There is no bypass path.
- Simultaneous push and pop in one cycle is legal when not full. The count is unchanged and the pointers both advance.
- Full
  - Input readys are low.
  - A pop in the same cycle does not reopen the readys until the next cycle.
- Wrap-around: the read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Reset mid-operation
  - The FIFO is emptied and the pointers and count go to 0.
  - The last-grant flag returns to MULDIV.
  - Buffered entries are discarded.
  - Entry payload registers are not reset.
- Reset values of outputs:
  - longp_wbck_o_valid=0, longp_excp_o_valid=0, oitf_ret_ena=0.
  - lsu_i_ready reads 1 when lsu_i_valid is high.
  - longp_wbck_o_flags=0 at all times.
- Output valids must be stable until accepted, because the head does not change without a pop.

## Structure
- Shared package/defines: the entry field widths (already in e203_defines.v) and a FIFO entry-struct width constant WBCK_Q_ENT_W = THREADS+FLEN+RFIDX_W+2.
- One sub-module: e203_exu_wbck_fifo.
  - Generic DEPTH×W synchronous FIFO with push, pop, full, empty and head data.
  - Holds the pointer and count logic.
- The top level holds the round-robin arbiter and the head dispatch demux.

## Test plan
- Single LSU completion (thread 01, wdat 0x1234, rd 5, err 0), out_ready=1 → longp_wbck_o_valid rises next cycle with matching fields. It pops that same cycle and oitf_ret_ena pulses once with thread 01.
- LSU and MULDIV both valid every cycle, out_ready=1 → grants alternate LSU, MDV, LSU, MDV; FIFO order matches the grant order.
- out_ready=0, DEPTH=2, three back-to-back LSU pushes → two accepted, then lsu_i_ready=0. Raise ready → entries drain in order and the third push is accepted only after the first pop.
- Head err=1 (thread 10) followed by err=0 → longp_excp_o_valid=1 and longp_wbck_o_valid=0 until excp_ready. The second entry then appears on the wbck port; two retire pulses occur with threads 10 and its own.
- Assert rst while two entries are held → next cycle both output valids=0, count 0, and the first tie goes to LSU.
- Continuous push and pop at full rate for 4×DEPTH entries → no loss or reorder across pointer wrap.
